// File: rtl/reg_file_scoreboard_pkg.sv
// reg_file_scoreboard_pkg: shared sizing constants for the register file scoreboard
package reg_file_scoreboard_pkg;
  localparam int NUM_REGS = 16;
  localparam int REG_ADDR_W = 4;
  localparam int PEND_W = 2;
endpackage

// File: rtl/reg_file_scoreboard_pending_ctr.sv
// reg_pending_ctr: per-register outstanding-write counter
// ports: clk, rst_n (async active-low), inc/dec/clr controls, count value, nonzero flag (registered)
module reg_pending_ctr
  import reg_file_scoreboard_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              dec,
  input  logic              clr,
  output logic [PEND_W-1:0] count,
  output logic              nonzero
);
  logic [PEND_W-1:0] nxt;
  always_comb nxt = clr ? '0 : (inc && !dec) ? count + 1'b1 : (dec && !inc) ? count - 1'b1 : count;
  // nonzero is its own flop so hold outputs come straight from a register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count <= '0;
      nonzero <= 1'b0;
    end else begin
      count <= nxt;
      nonzero <= |nxt;
    end
endmodule

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: 16-entry register file with per-register pending-write tracking
// ports: clk, rst_n (async active-low); reserve_valid/reserve_addr/reserve_ready claim a destination;
// wb_valid/wb_addr/wb_data write a register; flush drops all reservations;
// r00_Q..r15_Q register contents; hold_Q pending flags; wb_error sticky unexpected-writeback flag
module reg_file_scoreboard
  import reg_file_scoreboard_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int MAX_PEND = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reserve_valid,
  input  logic [REG_ADDR_W-1:0] reserve_addr,
  output logic                  reserve_ready,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  flush,
  output logic [DATA_W-1:0]     r00_Q,
  output logic [DATA_W-1:0]     r01_Q,
  output logic [DATA_W-1:0]     r02_Q,
  output logic [DATA_W-1:0]     r03_Q,
  output logic [DATA_W-1:0]     r04_Q,
  output logic [DATA_W-1:0]     r05_Q,
  output logic [DATA_W-1:0]     r06_Q,
  output logic [DATA_W-1:0]     r07_Q,
  output logic [DATA_W-1:0]     r08_Q,
  output logic [DATA_W-1:0]     r09_Q,
  output logic [DATA_W-1:0]     r10_Q,
  output logic [DATA_W-1:0]     r11_Q,
  output logic [DATA_W-1:0]     r12_Q,
  output logic [DATA_W-1:0]     r13_Q,
  output logic [DATA_W-1:0]     r14_Q,
  output logic [DATA_W-1:0]     r15_Q,
  output logic [NUM_REGS-1:0]   hold_Q,
  output logic                  wb_error
);
  localparam logic [PEND_W-1:0] MAX_P = PEND_W'(MAX_PEND);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [PEND_W-1:0] pend [NUM_REGS];
  logic accept;
  assign reserve_ready = pend[reserve_addr] < MAX_P;
  assign accept = reserve_valid && reserve_ready;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_ctr
    reg_pending_ctr u_ctr (
      .clk(clk),
      .rst_n(rst_n),
      .inc(accept && reserve_addr == REG_ADDR_W'(i)),
      .dec(wb_valid && wb_addr == REG_ADDR_W'(i) && hold_Q[i]),
      .clr(flush),
      .count(pend[i]),
      .nonzero(hold_Q[i])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    else if (wb_valid) regs[wb_addr] <= wb_data;
  // a flush cycle discards bookkeeping, so its writeback is never flagged
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wb_error <= 1'b0;
    else if (wb_valid && !flush && !hold_Q[wb_addr]) wb_error <= 1'b1;
  assign r00_Q = regs[0];
  assign r01_Q = regs[1];
  assign r02_Q = regs[2];
  assign r03_Q = regs[3];
  assign r04_Q = regs[4];
  assign r05_Q = regs[5];
  assign r06_Q = regs[6];
  assign r07_Q = regs[7];
  assign r08_Q = regs[8];
  assign r09_Q = regs[9];
  assign r10_Q = regs[10];
  assign r11_Q = regs[11];
  assign r12_Q = regs[12];
  assign r13_Q = regs[13];
  assign r14_Q = regs[14];
  assign r15_Q = regs[15];
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb_reg_file_scoreboard: directed self-checking bench for reg_file_scoreboard
module tb_reg_file_scoreboard;
  logic clk = 1'b0;
  logic rst_n;
  logic reserve_valid;
  logic [3:0] reserve_addr;
  logic reserve_ready;
  logic wb_valid;
  logic [3:0] wb_addr;
  logic [31:0] wb_data;
  logic flush;
  logic [31:0] r [16];
  logic [15:0] hold_Q;
  logic wb_error;
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  reg_file_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .reserve_valid(reserve_valid), .reserve_addr(reserve_addr), .reserve_ready(reserve_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .r00_Q(r[0]), .r01_Q(r[1]), .r02_Q(r[2]), .r03_Q(r[3]),
    .r04_Q(r[4]), .r05_Q(r[5]), .r06_Q(r[6]), .r07_Q(r[7]),
    .r08_Q(r[8]), .r09_Q(r[9]), .r10_Q(r[10]), .r11_Q(r[11]),
    .r12_Q(r[12]), .r13_Q(r[13]), .r14_Q(r[14]), .r15_Q(r[15]),
    .hold_Q(hold_Q), .wb_error(wb_error)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reserve_valid = 1'b0;
    wb_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    logic any;
    rst_n = 1'b0;
    reserve_addr = 4'd0;
    wb_addr = 4'd0;
    wb_data = 32'h0;
    idle();
    #12;
    total++; if (hold_Q !== 16'h0000) $display("FAIL rst_hold got %h want 0000", hold_Q); else passed++;
    total++; if (reserve_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", reserve_ready); else passed++;
    total++; if (wb_error !== 1'b0) $display("FAIL rst_wb_error got %b want 0", wb_error); else passed++;
    rst_n = 1'b1;
    step();
    step();
    any = 1'b0;
    for (int i = 0; i < 16; i++) if (r[i] !== 32'h0) any = 1'b1;
    total++; if (any !== 1'b0) $display("FAIL idle_regs got nonzero want all 0"); else passed++;
    total++; if (hold_Q !== 16'h0000) $display("FAIL idle_hold got %h want 0000", hold_Q); else passed++;
    total++; if (reserve_ready !== 1'b1) $display("FAIL idle_ready got %b want 1", reserve_ready); else passed++;
    total++; if (wb_error !== 1'b0) $display("FAIL idle_wb_error got %b want 0", wb_error); else passed++;
  endtask

  task automatic test_reserve_wb();
    reserve_valid = 1'b1; reserve_addr = 4'd5;
    step();
    idle();
    total++; if (hold_Q[5] !== 1'b1) $display("FAIL rw_hold5_c1 got %b want 1", hold_Q[5]); else passed++;
    step();
    total++; if (hold_Q[5] !== 1'b1) $display("FAIL rw_hold5_c2 got %b want 1", hold_Q[5]); else passed++;
    wb_valid = 1'b1; wb_addr = 4'd5; wb_data = 32'hDEADBEEF;
    step();
    idle();
    total++; if (hold_Q[5] !== 1'b0) $display("FAIL rw_hold5_c3 got %b want 0", hold_Q[5]); else passed++;
    total++; if (r[5] !== 32'hDEADBEEF) $display("FAIL rw_r05 got %h want deadbeef", r[5]); else passed++;
  endtask

  task automatic test_max_pend();
    reserve_valid = 1'b1; reserve_addr = 4'd3;
    step(); step(); step();
    #1;
    total++; if (reserve_ready !== 1'b0) $display("FAIL mp_ready_full got %b want 0", reserve_ready); else passed++;
    step();
    idle();
    total++; if (reserve_ready !== 1'b0) $display("FAIL mp_ready_after4 got %b want 0", reserve_ready); else passed++;
    wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 32'h00000001;
    step();
    idle();
    total++; if (reserve_ready !== 1'b1) $display("FAIL mp_ready_after_wb got %b want 1", reserve_ready); else passed++;
    wb_valid = 1'b1; wb_data = 32'h00000002;
    step(); step();
    idle();
    total++; if (hold_Q[3] !== 1'b0) $display("FAIL mp_hold3_drained got %b want 0", hold_Q[3]); else passed++;
    total++; if (wb_error !== 1'b0) $display("FAIL mp_wb_error got %b want 0", wb_error); else passed++;
  endtask

  task automatic test_same_cycle();
    reserve_valid = 1'b1; reserve_addr = 4'd7;
    step();
    wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 32'h12345678;
    step();
    idle();
    total++; if (hold_Q[7] !== 1'b1) $display("FAIL sc_hold7 got %b want 1", hold_Q[7]); else passed++;
    total++; if (r[7] !== 32'h12345678) $display("FAIL sc_r07 got %h want 12345678", r[7]); else passed++;
    wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 32'h87654321;
    step();
    idle();
    total++; if (hold_Q[7] !== 1'b0) $display("FAIL sc_hold7_drained got %b want 0", hold_Q[7]); else passed++;
    reserve_valid = 1'b1; reserve_addr = 4'd10;
    step();
    reserve_addr = 4'd11; wb_valid = 1'b1; wb_addr = 4'd10; wb_data = 32'hA0A0A0A0;
    step();
    idle();
    total++; if (hold_Q[11:10] !== 2'b10) $display("FAIL sc_diff_hold got %b want 10", hold_Q[11:10]); else passed++;
    wb_valid = 1'b1; wb_addr = 4'd11; wb_data = 32'hB1B1B1B1;
    step();
    idle();
    total++; if (wb_error !== 1'b0) $display("FAIL sc_wb_error got %b want 0", wb_error); else passed++;
  endtask

  task automatic test_flush();
    reserve_valid = 1'b1; reserve_addr = 4'd1;
    step();
    reserve_addr = 4'd2;
    step();
    total++; if (hold_Q !== 16'h0006) $display("FAIL fl_pre_hold got %h want 0006", hold_Q); else passed++;
    reserve_addr = 4'd4; flush = 1'b1;
    wb_valid = 1'b1; wb_addr = 4'd6; wb_data = 32'hC0FFEE00;
    step();
    idle();
    total++; if (hold_Q !== 16'h0000) $display("FAIL fl_hold got %h want 0000", hold_Q); else passed++;
    total++; if (r[6] !== 32'hC0FFEE00) $display("FAIL fl_r06 got %h want c0ffee00", r[6]); else passed++;
    total++; if (wb_error !== 1'b0) $display("FAIL fl_wb_error got %b want 0", wb_error); else passed++;
    step();
    total++; if (hold_Q[4] !== 1'b0) $display("FAIL fl_r4_reserved got %b want 0", hold_Q[4]); else passed++;
  endtask

  task automatic test_wb_error();
    wb_valid = 1'b1; wb_addr = 4'd9; wb_data = 32'hAAAA5555;
    step();
    idle();
    total++; if (r[9] !== 32'hAAAA5555) $display("FAIL we_r09 got %h want aaaa5555", r[9]); else passed++;
    total++; if (wb_error !== 1'b1) $display("FAIL we_set got %b want 1", wb_error); else passed++;
    total++; if (hold_Q[9] !== 1'b0) $display("FAIL we_hold9 got %b want 0", hold_Q[9]); else passed++;
    step(); step(); step();
    total++; if (wb_error !== 1'b1) $display("FAIL we_sticky got %b want 1", wb_error); else passed++;
    reserve_valid = 1'b1; reserve_addr = 4'd12;
    step();
    idle();
    rst_n = 1'b0;
    #1;
    total++; if (wb_error !== 1'b0) $display("FAIL we_async_clr got %b want 0", wb_error); else passed++;
    total++; if (r[9] !== 32'h0) $display("FAIL we_async_r09 got %h want 0", r[9]); else passed++;
    total++; if (r[5] !== 32'h0) $display("FAIL we_async_r05 got %h want 0", r[5]); else passed++;
    total++; if (hold_Q !== 16'h0000) $display("FAIL we_async_hold got %h want 0000", hold_Q); else passed++;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_reserve_wb();
    test_max_pend();
    test_same_cycle();
    test_flush();
    test_wb_error();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
